// File: rtl/gt_pattern_player.sv
// Multi-channel GT transmit pattern engine: per-lane pattern RAMs loaded by
// register strobes, played back in lock-step as a one-shot burst or a loop.
// Two-stage read pipeline (RAM read register, then output register).
module gt_pattern_player #(
    parameter int                CHN_NUM   = 6,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(32'h0000_00BC)
) (
    input  logic                      gt_clk,
    input  logic                      gt_rstb,
    input  logic                      ram_we,
    input  logic [7:0]                ram_idx,
    input  logic [ADDR_W-1:0]         ram_addr,
    input  logic [DATA_W-1:0]         ram_data,
    input  logic                      reg_start,
    input  logic                      reg_reset,
    input  logic                      loop_mode,
    input  logic [ADDR_W:0]           play_len,
    input  logic [CHN_NUM-1:0]        chn_en,
    output logic [CHN_NUM*DATA_W-1:0] gt_data,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               loop_cnt
);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t                    state, state_nxt;
    logic                      start_prev;
    logic                      start_edge;
    logic                      loop_lat;
    logic [ADDR_W-1:0]         last_lat;
    logic [ADDR_W-1:0]         last_eff;
    logic [CHN_NUM-1:0]        en_lat;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      at_last;
    logic                      pass_end;
    logic                      q_vld;
    logic                      q_last;
    logic [CHN_NUM*DATA_W-1:0] ram_q;

    assign start_edge = reg_start & ~start_prev & ~reg_reset;
    assign at_last    = (rd_addr == last_lat);
    // Final address of the run: one-shot, or loop with start released.
    assign pass_end   = (state == PLAY) && at_last && !(loop_lat && reg_start);
    assign busy       = (state != IDLE);

    // Last address of a pass; zero and oversize lengths both mean DEPTH.
    always_comb begin
        last_eff = '1;
        if (play_len != '0 && play_len < DEPTH_L)
            last_eff = play_len[ADDR_W-1:0] - 1'b1;
    end

    // Per-lane pattern RAM; unmatched indices (>= CHN_NUM) never write.
    for (genvar c = 0; c < CHN_NUM; c++) begin : g_chn
        logic [DATA_W-1:0] mem [DEPTH];

        // Write port plus registered read (read-during-write returns old data).
        always_ff @(posedge gt_clk) begin
            if (ram_we && ram_idx == 8'(c))
                mem[ram_addr] <= ram_data;
            ram_q[c*DATA_W +: DATA_W] <= mem[rd_addr];
        end
    end

    // State register.
    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; soft abort overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = PLAY;
            PLAY:    if (pass_end)   state_nxt = DRAIN;
            DRAIN:   if (!q_vld)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (reg_reset)
            state_nxt = IDLE;
    end

    // Run setup, address sequencing, pipeline valids and output register.
    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb) begin
            start_prev <= 1'b0;
            loop_lat   <= 1'b0;
            last_lat   <= '0;
            en_lat     <= '0;
            rd_addr    <= '0;
            q_vld      <= 1'b0;
            q_last     <= 1'b0;
            done       <= 1'b0;
            loop_cnt   <= '0;
            gt_data    <= {CHN_NUM{IDLE_WORD}};
        end else begin
            start_prev <= reg_start;
            if (reg_reset) begin
                rd_addr  <= '0;
                q_vld    <= 1'b0;
                q_last   <= 1'b0;
                done     <= 1'b0;
                loop_cnt <= '0;
                gt_data  <= {CHN_NUM{IDLE_WORD}};
            end else begin
                if (state == IDLE && start_edge) begin
                    loop_lat <= loop_mode;
                    last_lat <= last_eff;
                    en_lat   <= chn_en;
                    rd_addr  <= '0;
                    loop_cnt <= '0;
                end else if (state == PLAY) begin
                    if (at_last) begin
                        rd_addr <= '0;
                        if (loop_lat && reg_start)
                            loop_cnt <= loop_cnt + 16'd1;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                q_vld  <= (state == PLAY);
                q_last <= pass_end;
                done   <= q_vld & q_last;
                for (int unsigned i = 0; i < CHN_NUM; i++)
                    gt_data[i*DATA_W +: DATA_W] <= (q_vld && en_lat[i]) ?
                        ram_q[i*DATA_W +: DATA_W] : IDLE_WORD;
            end
        end
    end

endmodule

// File: tb/tb_gt_pattern_player.sv
// Directed bench for gt_pattern_player: one-shot, loop, length edges, lane
// enables, bad channel index, soft abort and asynchronous reset.
module tb_gt_pattern_player;

    localparam int          CHN  = 6;
    localparam int          DW   = 32;
    localparam int          DEP  = 16;
    localparam int          AW   = 4;
    localparam int          BW   = CHN*DW;
    localparam logic [31:0] IDLE = 32'h0000_00BC;

    logic              gt_clk;
    logic              gt_rstb;
    logic              ram_we;
    logic [7:0]        ram_idx;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_data;
    logic              reg_start;
    logic              reg_reset;
    logic              loop_mode;
    logic [AW:0]       play_len;
    logic [CHN-1:0]    chn_en;
    logic [BW-1:0]     gt_data;
    logic              busy;
    logic              done;
    logic [15:0]       loop_cnt;

    int n_total = 0;
    int n_bad   = 0;

    gt_pattern_player #(
        .CHN_NUM   (CHN),
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .IDLE_WORD (IDLE)
    ) dut (
        .gt_clk    (gt_clk),
        .gt_rstb   (gt_rstb),
        .ram_we    (ram_we),
        .ram_idx   (ram_idx),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .reg_start (reg_start),
        .reg_reset (reg_reset),
        .loop_mode (loop_mode),
        .play_len  (play_len),
        .chn_en    (chn_en),
        .gt_data   (gt_data),
        .busy      (busy),
        .done      (done),
        .loop_cnt  (loop_cnt)
    );

    initial gt_clk = 1'b0;
    always #5 gt_clk = ~gt_clk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane i, address a holds {i[7:0], a[23:0]}; disabled lanes idle.
    function automatic logic [BW-1:0] exp_bus(input int a, input logic [CHN-1:0] en);
        logic [BW-1:0] r;
        for (int i = 0; i < CHN; i++)
            r[i*DW +: DW] = en[i] ? {8'(i), 24'(a)} : IDLE;
        return r;
    endfunction

    task automatic tick;
        @(posedge gt_clk);
        #1;
    endtask

    task automatic wr(input int idx, input int addr, input logic [31:0] d);
        ram_we   = 1'b1;
        ram_idx  = 8'(idx);
        ram_addr = AW'(addr);
        ram_data = d;
        tick();
        ram_we   = 1'b0;
    endtask

    // One-shot run of L words; E0 is the first tick.
    task automatic play_once(input string tag, input logic [AW:0] plen, input int L,
                             input logic [CHN-1:0] en);
        loop_mode = 1'b0;
        play_len  = plen;
        chn_en    = en;
        reg_start = 1'b1;
        tick();
        reg_start = 1'b0;
        chk({tag, "_busy_e0"}, BW'(busy), BW'(1));
        for (int c = 1; c <= L + 2; c++) begin
            tick();
            if (c == 1) begin
                chk({tag, "_pre"}, gt_data, exp_bus(0, '0));
            end else if (c <= L + 1) begin
                chk({tag, "_data"}, gt_data, exp_bus(c - 2, en));
                chk({tag, "_done"}, BW'(done), BW'(c == L + 1));
                chk({tag, "_busy"}, BW'(busy), BW'(1));
            end else begin
                chk({tag, "_tail"}, gt_data, exp_bus(0, '0));
                chk({tag, "_busy_end"}, BW'(busy), BW'(0));
                chk({tag, "_done_end"}, BW'(done), BW'(0));
            end
        end
    endtask

    initial begin
        gt_rstb   = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = '0;
        ram_addr  = '0;
        ram_data  = '0;
        reg_start = 1'b0;
        reg_reset = 1'b0;
        loop_mode = 1'b0;
        play_len  = '0;
        chn_en    = '1;
        tick();
        tick();
        chk("rst_data", gt_data, exp_bus(0, '0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_done", BW'(done), BW'(0));
        chk("rst_cnt", BW'(loop_cnt), BW'(0));
        gt_rstb = 1'b1;
        tick();

        for (int ch = 0; ch < CHN; ch++)
            for (int a = 0; a < DEP; a++)
                wr(ch, a, {8'(ch), 24'(a)});

        play_once("oneshot", 5'd8, 8, '1);

        // Loop L=4: start held through 10 wraps, released mid 11th pass.
        loop_mode = 1'b1;
        play_len  = 5'd4;
        chn_en    = '1;
        reg_start = 1'b1;
        tick();
        for (int c = 1; c <= 46; c++) begin
            tick();
            if (c == 41)
                reg_start = 1'b0;
            if (c >= 2 && c <= 45) begin
                chk("loop_data", gt_data, exp_bus((c - 2) % 4, '1));
                chk("loop_done", BW'(done), BW'(c == 45));
                chk("loop_busy", BW'(busy), BW'(1));
            end
            if (c <= 40 && c % 4 == 0)
                chk("loop_cnt", BW'(loop_cnt), BW'(c / 4));
            if (c == 45)
                chk("loop_cnt_final", BW'(loop_cnt), BW'(10));
            if (c == 46) begin
                chk("loop_tail", gt_data, exp_bus(0, '0));
                chk("loop_busy_end", BW'(busy), BW'(0));
                chk("loop_done_end", BW'(done), BW'(0));
            end
        end

        play_once("len0", 5'd0, DEP, '1);
        play_once("lenover", 5'(DEP + 5), DEP, '1);

        // Loop L=1: constant word, counter steps every cycle.
        loop_mode = 1'b1;
        play_len  = 5'd1;
        chn_en    = '1;
        reg_start = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c <= 8)
                chk("len1_cnt", BW'(loop_cnt), BW'(c));
            else if (c <= 10)
                chk("len1_cnt_hold", BW'(loop_cnt), BW'(8));
            if (c >= 2 && c <= 10) begin
                chk("len1_data", gt_data, exp_bus(0, '1));
                chk("len1_done", BW'(done), BW'(c == 10));
            end
            if (c == 11) begin
                chk("len1_tail", gt_data, exp_bus(0, '0));
                chk("len1_busy_end", BW'(busy), BW'(0));
            end
            if (c == 8)
                reg_start = 1'b0;
        end

        for (int a = 0; a < 8; a++)
            wr(7, a, 32'hDEAD_BEEF);
        play_once("idx7", 5'd8, 8, '1);

        play_once("lane_en", 5'd8, 8, 6'b101010);

        // Soft abort with a coincident start edge.
        loop_mode = 1'b1;
        play_len  = 5'd2;
        chn_en    = '1;
        reg_start = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 4)
                reg_start = 1'b0;
        end
        chk("abort_pre_cnt", BW'(loop_cnt), BW'(2));
        chk("abort_pre_data", gt_data, exp_bus(1, '1));
        reg_reset = 1'b1;
        reg_start = 1'b1;
        tick();
        chk("abort_data", gt_data, exp_bus(0, '0));
        chk("abort_busy", BW'(busy), BW'(0));
        chk("abort_done", BW'(done), BW'(0));
        chk("abort_cnt", BW'(loop_cnt), BW'(0));
        reg_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_norestart_busy", BW'(busy), BW'(0));
            chk("abort_norestart_data", gt_data, exp_bus(0, '0));
        end
        reg_start = 1'b0;
        tick();
        play_once("restart", 5'd8, 8, '1);

        // Asynchronous reset in the middle of a loop run.
        loop_mode = 1'b1;
        play_len  = 5'd4;
        chn_en    = '1;
        reg_start = 1'b1;
        tick();
        for (int c = 1; c <= 6; c++)
            tick();
        reg_start = 1'b0;
        chk("arst_pre_cnt", BW'(loop_cnt), BW'(1));
        chk("arst_pre_data", gt_data, exp_bus(0, '1));
        #2;
        gt_rstb = 1'b0;
        #1;
        chk("arst_data", gt_data, exp_bus(0, '0));
        chk("arst_busy", BW'(busy), BW'(0));
        chk("arst_done", BW'(done), BW'(0));
        chk("arst_cnt", BW'(loop_cnt), BW'(0));
        tick();
        gt_rstb = 1'b1;
        tick();
        play_once("post_arst", 5'd8, 8, '1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
